// File: rtl/bldc_pkg.sv
// bldc_pkg: shared hall codes, meter FSM states and saturation limit helpers
package bldc_pkg;
  localparam logic [2:0] HALL_ILLEGAL_0 = 3'b000;
  localparam logic [2:0] HALL_ILLEGAL_7 = 3'b111;
  typedef enum logic [1:0] {IDLE, ARMING, MEASURING} meter_state_e;
  function automatic logic hall_legal(input logic [2:0] h);
    return (h != HALL_ILLEGAL_0) && (h != HALL_ILLEGAL_7);
  endfunction
  function automatic longint sat_max(input int w);
    return (longint'(1) <<< (w - 1)) - 1;
  endfunction
  function automatic longint sat_min(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction
endpackage

// File: rtl/hall_debouncer.sv
// hall_debouncer: 2-FF synchroniser plus stability filter producing the accepted hall state
module hall_debouncer #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk_div,
  input  logic       reset_n,
  input  logic [2:0] hall,
  output logic [2:0] state,
  output logic       changed
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [2:0] s1_q, s2_q, cand_q, cand_d, acc_q, acc_d;
  logic [CW-1:0] run_q, run_d;
  logic chg_q, chg_d;
  always_comb begin
    run_d = (s2_q != cand_q) ? CW'(1) : (run_q == CW'(DEBOUNCE_CYCLES)) ? run_q : run_q + 1'b1;
    cand_d = s2_q;
    acc_d = (run_d == CW'(DEBOUNCE_CYCLES)) ? s2_q : acc_q;
    chg_d = acc_d != acc_q;
  end
  always_ff @(posedge clk_div or negedge reset_n) begin
    if (!reset_n) begin
      s1_q <= '0;
      s2_q <= '0;
      cand_q <= '0;
      run_q <= '0;
      acc_q <= '0;
      chg_q <= 1'b0;
    end else begin
      s1_q <= hall;
      s2_q <= s1_q;
      cand_q <= cand_d;
      run_q <= run_d;
      acc_q <= acc_d;
      chg_q <= chg_d;
    end
  end
  assign state = acc_q;
  assign changed = chg_q;
endmodule

// File: rtl/hall_period_meter.sv
// hall_period_meter: times hall commutation edges and reports saturated period error
module hall_period_meter import bldc_pkg::*; #(
  parameter int          DATA_WIDTH      = 16,
  parameter int          PRESCALE        = 1,
  parameter int          DEBOUNCE_CYCLES = 4,
  parameter int unsigned STALL_LIMIT     = 32'hFFF0
) (
  input  logic                  clk_div,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic [2:0]            hall,
  input  logic [DATA_WIDTH-1:0] target_period,
  output logic [DATA_WIDTH-1:0] period_speed,
  output logic                  period_valid,
  output logic                  stalled,
  output logic                  hall_fault
);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [DATA_WIDTH-1:0] CMAX = '1;
  localparam logic [DATA_WIDTH-1:0] LIMIT = DATA_WIDTH'(STALL_LIMIT);
  localparam logic signed [DATA_WIDTH:0] EMAX = (DATA_WIDTH+1)'(sat_max(DATA_WIDTH));
  localparam logic signed [DATA_WIDTH:0] EMIN = (DATA_WIDTH+1)'(sat_min(DATA_WIDTH));
  meter_state_e st_q, st_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [DATA_WIDTH-1:0] cnt_q, cnt_d, meas, ps_q, ps_d, err_s;
  logic [2:0] hall_acc, last_q, last_d;
  logic signed [DATA_WIDTH:0] err;
  logic hall_chg, legal, edge_hit, tick, pv_q, pv_d, stl_q, stl_d, flt_q, flt_d;
  hall_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
    .clk_div(clk_div),
    .reset_n(reset_n),
    .hall(hall),
    .state(hall_acc),
    .changed(hall_chg)
  );
  always_comb begin
    tick = pre_q == PW'(PRESCALE - 1);
    legal = hall_legal(hall_acc);
    edge_hit = legal && (hall_acc != last_q);
    last_d = legal ? hall_acc : last_q;
    flt_d = flt_q || (hall_chg && !legal);
    meas = (tick && cnt_q != CMAX) ? cnt_q + 1'b1 : cnt_q;
    err = $signed({1'b0, meas}) - $signed({1'b0, target_period});
    err_s = (err > EMAX) ? EMAX[DATA_WIDTH-1:0] : (err < EMIN) ? EMIN[DATA_WIDTH-1:0] : err[DATA_WIDTH-1:0];
    pre_d = tick ? '0 : pre_q + 1'b1;
    cnt_d = meas;
    st_d = st_q;
    ps_d = ps_q;
    pv_d = 1'b0;
    stl_d = stl_q;
    if (!enable) begin
      st_d = IDLE;
      pre_d = '0;
      cnt_d = '0;
      stl_d = 1'b1;
    end else if (st_q == IDLE) begin
      st_d = ARMING;
      pre_d = '0;
      cnt_d = '0;
    end else if (edge_hit) begin
      st_d = MEASURING;
      pre_d = '0;
      cnt_d = '0;
      stl_d = 1'b0;
      pv_d = st_q == MEASURING;
      ps_d = (st_q == MEASURING) ? err_s : ps_q;
    end else if (st_q == MEASURING && meas >= LIMIT) begin
      st_d = ARMING;
      pre_d = '0;
      cnt_d = '0;
      stl_d = 1'b1;
      pv_d = 1'b1;
      ps_d = EMAX[DATA_WIDTH-1:0];
    end
  end
  always_ff @(posedge clk_div or negedge reset_n) begin
    if (!reset_n) begin
      st_q <= IDLE;
      pre_q <= '0;
      cnt_q <= '0;
      last_q <= '0;
      ps_q <= EMAX[DATA_WIDTH-1:0];
      pv_q <= 1'b0;
      stl_q <= 1'b1;
      flt_q <= 1'b0;
    end else begin
      st_q <= st_d;
      pre_q <= pre_d;
      cnt_q <= cnt_d;
      last_q <= last_d;
      ps_q <= ps_d;
      pv_q <= pv_d;
      stl_q <= stl_d;
      flt_q <= flt_d;
    end
  end
  assign period_speed = ps_q;
  assign period_valid = pv_q;
  assign stalled = stl_q;
  assign hall_fault = flt_q;
endmodule
